// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode CSR file: CSR addresses, the
// csr_op encoding, exception cause codes, WARL masks and mcountinhibit bit
// positions.
package csr_pkg;

  // CSR instruction operation, matching funct3[1:0] of CSRRW/CSRRS/CSRRC.
  typedef enum logic [1:0] {
    CSR_OP_WRITE = 2'd1,
    CSR_OP_SET   = 2'd2,
    CSR_OP_CLEAR = 2'd3
  } csr_op_e;

  // Machine information registers (read-only address space).
  localparam logic [11:0] CSR_MVENDORID = 12'hF11;
  localparam logic [11:0] CSR_MARCHID   = 12'hF12;
  localparam logic [11:0] CSR_MIMPID    = 12'hF13;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;

  // Machine trap setup and handling.
  localparam logic [11:0] CSR_MSTATUS       = 12'h300;
  localparam logic [11:0] CSR_MISA          = 12'h301;
  localparam logic [11:0] CSR_MIE           = 12'h304;
  localparam logic [11:0] CSR_MTVEC         = 12'h305;
  localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;
  localparam logic [11:0] CSR_MHPMEVENT_FIRST = 12'h323;
  localparam logic [11:0] CSR_MHPMEVENT_LAST  = 12'h33F;
  localparam logic [11:0] CSR_MSCRATCH      = 12'h340;
  localparam logic [11:0] CSR_MEPC          = 12'h341;
  localparam logic [11:0] CSR_MCAUSE        = 12'h342;
  localparam logic [11:0] CSR_MTVAL         = 12'h343;
  localparam logic [11:0] CSR_MIP           = 12'h344;

  // Counter halves: address = base + counter index (0..31).
  localparam logic [11:0] CSR_CNT_LO_BASE = 12'hB00;
  localparam logic [11:0] CSR_CNT_HI_BASE = 12'hB80;

  // Exception cause codes that load mtval.
  localparam logic [31:0] CAUSE_MISALIGNED_FETCH = 32'd0;
  localparam logic [31:0] CAUSE_ILLEGAL_INSTR    = 32'd2;
  localparam logic [31:0] CAUSE_BREAKPOINT       = 32'd3;
  localparam logic [31:0] CAUSE_MISALIGNED_LOAD  = 32'd4;
  localparam logic [31:0] CAUSE_MISALIGNED_STORE = 32'd6;

  // WARL masks.
  localparam logic [31:0] MSTATUS_WMASK = 32'h0000_0088;  // MIE, MPIE
  localparam logic [31:0] MSTATUS_MPP   = 32'h0000_1800;  // MPP hard 2'b11
  localparam logic [31:0] MIE_WMASK     = 32'h0000_0888;  // MSIE, MTIE, MEIE
  localparam logic [31:0] MEPC_WMASK    = 32'hFFFF_FFFC;

  // mcountinhibit bit positions (same as the counter address index).
  localparam int unsigned CNTINH_CY       = 0;
  localparam int unsigned CNTINH_IR       = 2;
  localparam int unsigned CNTINH_HPM_BASE = 3;

  // Writable mcountinhibit bits for a given number of HPM counters.
  function automatic logic [31:0] mcountinhibit_mask(input int unsigned num_hpm);
    logic [31:0] m;
    m = '0;
    m[CNTINH_CY] = 1'b1;
    m[CNTINH_IR] = 1'b1;
    for (int i = 0; i < 29; i++) begin
      if (i < int'(num_hpm)) m[CNTINH_HPM_BASE + i] = 1'b1;
    end
    return m;
  endfunction

  // Counter slot (0 = mcycle, 1 = minstret, 2.. = hpm) to address index.
  function automatic logic [4:0] cnt_addr_idx(input int unsigned slot);
    if (slot == 0) return 5'd0;
    if (slot == 1) return 5'd2;
    return 5'(slot + 1);
  endfunction

endpackage

// File: rtl/csr_file_v2_if.sv
// CSR access bus between the core control FSM (master) and the CSR file
// (slave).
interface csr_file_v2_if;
  import csr_pkg::*;

  logic        csr_we;
  csr_op_e     csr_op;
  logic [11:0] csr_reg;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        csr_illegal;

  modport master (
    output csr_we, csr_op, csr_reg, csr_wdata,
    input  csr_rdata, csr_illegal
  );

  modport slave (
    input  csr_we, csr_op, csr_reg, csr_wdata,
    output csr_rdata, csr_illegal
  );
endinterface

// File: rtl/csr_counter64.sv
// 64-bit performance counter with independently writable halves.
// Priority: lo write, hi write, inhibit (hold), increment.
module csr_counter64 (
  input  logic        clk,
  input  logic        rst,
  input  logic        inhibit,
  input  logic        inc,
  input  logic        we_lo,
  input  logic        we_hi,
  input  logic [31:0] wdata,
  output logic [63:0] count
);

  // Counter register: software writes win over counting.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (we_lo) begin
      count[31:0] <= wdata;
    end else if (we_hi) begin
      count[63:32] <= wdata;
    end else if (!inhibit && inc) begin
      count <= count + 64'd1;
    end
  end

endmodule

// File: rtl/csr_file_v2.sv
// Machine-mode CSR file for the multicycle RV32 core: 64-bit mcycle,
// minstret and NUM_HPM event counters, mcountinhibit, WARL masking and a
// vectored mtvec with a computed trap target.
// Optional: define CSR_ILLEGAL_ACCESS_EN to flag (and suppress) accesses to
// unimplemented CSRs and writes to read-only CSRs on csr_illegal.
module csr_file_v2
  import csr_pkg::*;
#(
  parameter int unsigned NUM_HPM  = 4,
  parameter logic [31:0] HART_ID  = 32'h0,
  parameter logic [31:0] MISA_VAL = 32'h4000_0100,
  localparam int unsigned HPM_W   = (NUM_HPM == 0) ? 1 : NUM_HPM
) (
  input  logic              clk,
  input  logic              rst,
  csr_file_v2_if.slave      bus,
  input  logic [31:0]       pc,
  input  logic [31:0]       instruction,
  input  logic [31:0]       misaligned_addr,
  input  logic              instr_retire,
  input  logic [HPM_W-1:0]  hpm_event,
  input  logic              trap_pending,
  input  logic [31:0]       trap_cause,
  input  logic              trap_finish,
  input  logic [31:0]       mip,
  output logic [31:0]       mie,
  output logic              irq_en,
  output logic [31:0]       mepc,
  output logic [31:0]       trap_target
);

  localparam int unsigned   NUM_CNT     = 2 + NUM_HPM;
  localparam logic [31:0]   CNTINH_MASK = mcountinhibit_mask(NUM_HPM);

  logic        mstatus_mie_q, mstatus_mpie_q;
  logic [31:0] mtvec_q, mscratch_q, mcause_q, mtval_q, mcountinhibit_q;
  logic [31:0] mstatus_rd;
  logic [63:0] cnt_val [NUM_CNT];

  logic [31:0] rdata;
  logic        implemented;
  logic        illegal;
  logic        wr_en;
  logic [31:0] wdata_new;
  logic        mtval_upd;
  logic [31:0] mtval_hw;
  logic [31:0] mtvec_base;

  assign mstatus_rd = {19'b0, 2'b11, 3'b0, mstatus_mpie_q, 3'b0, mstatus_mie_q, 3'b0};

  // Combinational read mux and address decode.
  // NOTE: every variable gets a default before the case so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    rdata       = '0;
    implemented = 1'b1;
    case (bus.csr_reg)
      CSR_MVENDORID, CSR_MARCHID, CSR_MIMPID: rdata = '0;
      CSR_MHARTID:       rdata = HART_ID;
      CSR_MSTATUS:       rdata = mstatus_rd;
      CSR_MISA:          rdata = MISA_VAL;
      CSR_MIE:           rdata = mie;
      CSR_MTVEC:         rdata = mtvec_q;
      CSR_MCOUNTINHIBIT: rdata = mcountinhibit_q;
      CSR_MSCRATCH:      rdata = mscratch_q;
      CSR_MEPC:          rdata = mepc;
      CSR_MCAUSE:        rdata = mcause_q;
      CSR_MTVAL:         rdata = mtval_q;
      CSR_MIP:           rdata = mip;
      default: begin
        if (bus.csr_reg[11:5] == CSR_CNT_LO_BASE[11:5] ||
            bus.csr_reg[11:5] == CSR_CNT_HI_BASE[11:5]) begin
          // Counter halves; indices without a counter stay unimplemented.
          implemented = 1'b0;
          for (int s = 0; s < NUM_CNT; s++) begin
            if (bus.csr_reg[4:0] == cnt_addr_idx(s)) begin
              implemented = 1'b1;
              rdata = bus.csr_reg[7] ? cnt_val[s][63:32] : cnt_val[s][31:0];
            end
          end
        end else if (bus.csr_reg >= CSR_MHPMEVENT_FIRST &&
                     bus.csr_reg <= CSR_MHPMEVENT_LAST) begin
          rdata = '0;  // events are hard-wired to hpm_event
        end else begin
          implemented = 1'b0;
        end
      end
    endcase
  end

`ifdef CSR_ILLEGAL_ACCESS_EN
  assign illegal = !implemented ||
                   (bus.csr_we && (bus.csr_reg[11:10] == 2'b11 || bus.csr_reg == CSR_MIP));
`else
  logic unused_implemented;
  assign unused_implemented = implemented;
  assign illegal = 1'b0;
`endif

  assign bus.csr_rdata   = rdata;
  assign bus.csr_illegal = illegal;
  assign wr_en           = bus.csr_we && !illegal;

  // Read-modify-write value from the current read of csr_reg.
  always_comb begin
    case (bus.csr_op)
      CSR_OP_WRITE: wdata_new = bus.csr_wdata;
      CSR_OP_SET:   wdata_new = rdata | bus.csr_wdata;
      CSR_OP_CLEAR: wdata_new = rdata & ~bus.csr_wdata;
      default:      wdata_new = rdata;
    endcase
  end

  // mtval source for exceptions that report a value.
  always_comb begin
    mtval_upd = 1'b0;
    mtval_hw  = '0;
    if (!trap_cause[31]) begin
      case (trap_cause)
        CAUSE_BREAKPOINT:    begin mtval_upd = 1'b1; mtval_hw = pc;          end
        CAUSE_ILLEGAL_INSTR: begin mtval_upd = 1'b1; mtval_hw = instruction; end
        CAUSE_MISALIGNED_FETCH, CAUSE_MISALIGNED_LOAD, CAUSE_MISALIGNED_STORE: begin
          mtval_upd = 1'b1;
          mtval_hw  = misaligned_addr;
        end
        default: ;
      endcase
    end
  end

  // mstatus: trap entry, then mret, then software write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
    end else if (trap_pending) begin
      mstatus_mpie_q <= mstatus_mie_q;
      mstatus_mie_q  <= 1'b0;
    end else if (trap_finish) begin
      mstatus_mie_q  <= mstatus_mpie_q;
      mstatus_mpie_q <= 1'b1;
    end else if (wr_en && bus.csr_reg == CSR_MSTATUS) begin
      mstatus_mie_q  <= wdata_new[3];
      mstatus_mpie_q <= wdata_new[7];
    end
  end

  // Trap-state registers: trap entry overrides software writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mepc     <= '0;
      mcause_q <= '0;
      mtval_q  <= '0;
    end else if (trap_pending) begin
      mepc     <= pc & MEPC_WMASK;
      mcause_q <= trap_cause;
      if (mtval_upd) mtval_q <= mtval_hw;
    end else if (wr_en) begin
      if (bus.csr_reg == CSR_MEPC)   mepc     <= wdata_new & MEPC_WMASK;
      if (bus.csr_reg == CSR_MCAUSE) mcause_q <= wdata_new;
      if (bus.csr_reg == CSR_MTVAL)  mtval_q  <= wdata_new;
    end
  end

  // Software-only registers, never touched by trap hardware.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mie             <= '0;
      mtvec_q         <= '0;
      mscratch_q      <= '0;
      mcountinhibit_q <= '0;
    end else if (wr_en) begin
      case (bus.csr_reg)
        CSR_MIE:           mie <= wdata_new & MIE_WMASK;
        CSR_MTVEC:         mtvec_q <= {wdata_new[31:2], 1'b0, wdata_new[1:0] == 2'b01};
        CSR_MSCRATCH:      mscratch_q <= wdata_new;
        CSR_MCOUNTINHIBIT: mcountinhibit_q <= wdata_new & CNTINH_MASK;
        default: ;
      endcase
    end
  end

  assign irq_en      = mstatus_mie_q;
  assign mtvec_base  = {mtvec_q[31:2], 2'b00};
  assign trap_target = (mtvec_q[1:0] == 2'b01 && trap_cause[31])
                     ? mtvec_base + {25'b0, trap_cause[4:0], 2'b00}
                     : mtvec_base;

  for (genvar g = 0; g < NUM_CNT; g++) begin : g_cnt
    localparam logic [4:0] IDX = cnt_addr_idx(g);
    logic inc;

    if (g == 0) begin : g_cy
      assign inc = 1'b1;
    end else if (g == 1) begin : g_ir
      assign inc = instr_retire;
    end else begin : g_hpm
      assign inc = hpm_event[g-2];
    end

    csr_counter64 u_cnt (
      .clk     (clk),
      .rst     (rst),
      .inhibit (mcountinhibit_q[IDX]),
      .inc     (inc),
      .we_lo   (wr_en && bus.csr_reg == {CSR_CNT_LO_BASE[11:5], IDX}),
      .we_hi   (wr_en && bus.csr_reg == {CSR_CNT_HI_BASE[11:5], IDX}),
      .wdata   (wdata_new),
      .count   (cnt_val[g])
    );
  end

endmodule
